// File: rtl/jt1942_rom_arb_if.sv
// ROM request slots and SDRAM read channel for jt1942_rom_arb.
// slave: arbiter side. master: game core plus SDRAM controller side.
interface jt1942_rom_arb_if;
  logic        downloading;

  logic        main_cs;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_ok;

  logic        snd_cs;
  logic [14:0] snd_addr;
  logic [7:0]  snd_data;
  logic        snd_ok;

  logic        char_cs;
  logic [12:0] char_addr;
  logic [15:0] char_data;
  logic        char_ok;

  logic        scr_cs;
  logic [14:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ok;

  logic        obj_cs;
  logic [14:0] obj_addr;
  logic [15:0] obj_data;
  logic        obj_ok;

  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] data_read;

  modport slave (
    input  downloading,
    input  main_cs, main_addr, snd_cs, snd_addr, char_cs, char_addr,
    input  scr_cs, scr_addr, obj_cs, obj_addr,
    output main_data, main_ok, snd_data, snd_ok, char_data, char_ok,
    output scr_data, scr_ok, obj_data, obj_ok,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, data_read
  );

  modport master (
    output downloading,
    output main_cs, main_addr, snd_cs, snd_addr, char_cs, char_addr,
    output scr_cs, scr_addr, obj_cs, obj_addr,
    input  main_data, main_ok, snd_data, snd_ok, char_data, char_ok,
    input  scr_data, scr_ok, obj_data, obj_ok,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jt1942_rom_arb.sv
// SDRAM read arbiter for the 1942 ROM slots: one-word cache per slot,
// fixed-priority miss servicing (main > snd > char > scr > obj).
module jt1942_rom_arb #(
  parameter logic [21:0] SND_OFFSET  = 22'h01_4000,
  parameter logic [21:0] CHAR_OFFSET = 22'h01_8000,
  parameter logic [21:0] SCR_OFFSET  = 22'h01_A000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h02_2000
) (
  input logic             clk,
  input logic             rst,
  jt1942_rom_arb_if.slave bus
);

  localparam int NumSlots = 5;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                            state_q;
  logic                              req_q;
  logic [21:0]                       addr_q;
  logic [2:0]                        slot_q;
  logic [15:0]                       slot_addr_q;
  logic [NumSlots-1:0]               valid_q;
  logic [NumSlots-1:0][15:0]         cache_addr_q;
  logic [NumSlots-1:0][15:0]         cache_data_q;

  logic [NumSlots-1:0][15:0]         word_addr;
  logic [NumSlots-1:0][21:0]         offset;
  logic [NumSlots-1:0]               cs;
  logic [NumSlots-1:0]               hit;
  logic [NumSlots-1:0]               pending;
  logic [2:0]                        grant;

  // Byte slots address 8-bit ROM through 16-bit words; bit 0 picks the byte.
  assign word_addr[0] = bus.main_addr[16:1];
  assign word_addr[1] = {2'b0, bus.snd_addr[14:1]};
  assign word_addr[2] = {3'b0, bus.char_addr};
  assign word_addr[3] = {1'b0, bus.scr_addr};
  assign word_addr[4] = {1'b0, bus.obj_addr};

  assign offset[0] = 22'h0;
  assign offset[1] = SND_OFFSET;
  assign offset[2] = CHAR_OFFSET;
  assign offset[3] = SCR_OFFSET;
  assign offset[4] = OBJ_OFFSET;

  assign cs = {bus.obj_cs, bus.scr_cs, bus.char_cs, bus.snd_cs, bus.main_cs};

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      hit[i] = valid_q[i] & (word_addr[i] == cache_addr_q[i]);
    end
  end

  assign pending = cs & ~hit & {NumSlots{~bus.downloading}};

  // Lowest index wins: scan from the bottom of the priority list upwards.
  always_comb begin
    grant = 3'd0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (pending[i]) grant = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      addr_q       <= '0;
      slot_q       <= '0;
      slot_addr_q  <= '0;
      valid_q      <= '0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else begin
      if (bus.downloading) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|pending) begin
            slot_q      <= grant;
            slot_addr_q <= word_addr[grant];
            addr_q      <= offset[grant] + {6'd0, word_addr[grant]};
            req_q       <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (bus.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.data_rdy) begin
            cache_data_q[slot_q] <= bus.data_read;
            cache_addr_q[slot_q] <= slot_addr_q;
            if (!bus.downloading) valid_q[slot_q] <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;

  assign bus.main_ok = bus.main_cs & hit[0] & ~bus.downloading;
  assign bus.snd_ok  = bus.snd_cs  & hit[1] & ~bus.downloading;
  assign bus.char_ok = bus.char_cs & hit[2] & ~bus.downloading;
  assign bus.scr_ok  = bus.scr_cs  & hit[3] & ~bus.downloading;
  assign bus.obj_ok  = bus.obj_cs  & hit[4] & ~bus.downloading;

  assign bus.main_data = bus.main_addr[0] ? cache_data_q[0][15:8] : cache_data_q[0][7:0];
  assign bus.snd_data  = bus.snd_addr[0]  ? cache_data_q[1][15:8] : cache_data_q[1][7:0];
  assign bus.char_data = cache_data_q[2];
  assign bus.scr_data  = cache_data_q[3];
  assign bus.obj_data  = cache_data_q[4];

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// Directed bench for jt1942_rom_arb: vector table plus multi-cycle sequences.
module tb_jt1942_rom_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt1942_rom_arb_if bus ();
  jt1942_rom_arb_if bus2 ();

  jt1942_rom_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  jt1942_rom_arb #(
    .OBJ_OFFSET (22'h3F_FFFF)
  ) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct {
    logic [4:0]  cs;
    logic [16:0] ma;
    logic [14:0] sa;
    logic [12:0] ca;
    logic [14:0] ra;
    logic [14:0] oa;
    logic [21:0] exp_addr;
    logic [15:0] rd;
    int          slot;
    logic [15:0] exp_dout;
    logic [4:0]  exp_ok;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] okv();
    return {bus.obj_ok, bus.scr_ok, bus.char_ok, bus.snd_ok, bus.main_ok};
  endfunction

  function automatic logic [15:0] dout(input int s);
    case (s)
      0:       return {8'h00, bus.main_data};
      1:       return {8'h00, bus.snd_data};
      2:       return bus.char_data;
      3:       return bus.scr_data;
      default: return bus.obj_data;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.downloading = 0; bus.sdram_ack = 0; bus.data_rdy = 0; bus.data_read = '0;
    bus.main_cs = 0; bus.main_addr = '0; bus.snd_cs = 0; bus.snd_addr = '0;
    bus.char_cs = 0; bus.char_addr = '0; bus.scr_cs = 0; bus.scr_addr = '0;
    bus.obj_cs = 0; bus.obj_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Bounded wait for a request, then check its address.
  task automatic expect_req(input string name, input logic [21:0] addr);
    for (int i = 0; i < 20 && !bus.sdram_req; i++) step();
    chk({name, "_req"}, 32'(bus.sdram_req), 32'd1);
    chk({name, "_addr"}, 32'(bus.sdram_addr), 32'(addr));
  endtask

  task automatic ack_cycle();
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
  endtask

  task automatic data_cycle(input logic [15:0] d);
    bus.data_read = d;
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy  = 1'b0;
    #1;
  endtask

  initial begin
    int reqs;
    clear_inputs();
    bus2.downloading = 0; bus2.sdram_ack = 0; bus2.data_rdy = 0; bus2.data_read = '0;
    bus2.main_cs = 0; bus2.main_addr = '0; bus2.snd_cs = 0; bus2.snd_addr = '0;
    bus2.char_cs = 0; bus2.char_addr = '0; bus2.scr_cs = 0; bus2.scr_addr = '0;
    bus2.obj_cs = 0; bus2.obj_addr = '0;

    vecs[0] = '{5'b00001, 17'h00123, 15'h0,    13'h0,    15'h0,    15'h0,
                22'h000091, 16'hABCD, 0, 16'h00AB, 5'b00001};
    vecs[1] = '{5'b11110, 17'h0,     15'h0004, 13'h0010, 15'h7FFF, 15'h0100,
                22'h014002, 16'h1234, 1, 16'h0034, 5'b00010};
    vecs[2] = '{5'b11100, 17'h0,     15'h0004, 13'h0010, 15'h7FFF, 15'h0100,
                22'h018010, 16'h5555, 2, 16'h5555, 5'b00100};
    vecs[3] = '{5'b11000, 17'h0,     15'h0004, 13'h0010, 15'h7FFF, 15'h0100,
                22'h021FFF, 16'h0F0F, 3, 16'h0F0F, 5'b01000};
    vecs[4] = '{5'b10000, 17'h0,     15'h0004, 13'h0010, 15'h7FFF, 15'h0100,
                22'h022100, 16'hCAFE, 4, 16'hCAFE, 5'b10000};
    vecs[5] = '{5'b00010, 17'h0,     15'h7FFF, 13'h0010, 15'h7FFF, 15'h0100,
                22'h017FFF, 16'hBEEF, 1, 16'h00BE, 5'b00010};
    vecs[6] = '{5'b00001, 17'h1FFFF, 15'h0,    13'h0,    15'h0,    15'h0,
                22'h00FFFF, 16'h8001, 0, 16'h0080, 5'b00001};

    // Reset state, with slots selected so outputs are visible.
    #3;
    bus.main_cs = 1; bus.main_addr = 17'h00001; bus.char_cs = 1;
    #1;
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    chk("rst_ok", 32'(okv()), 32'd0);
    chk("rst_main_data", 32'(bus.main_data), 32'd0);
    chk("rst_char_data", 32'(bus.char_data), 32'd0);
    clear_inputs();
    step();
    rst = 1'b0;
    #1;

    // Table: each row is one full miss/request/fill transaction.
    for (int v = 0; v < 7; v++) begin
      {bus.obj_cs, bus.scr_cs, bus.char_cs, bus.snd_cs, bus.main_cs} = vecs[v].cs;
      bus.main_addr = vecs[v].ma; bus.snd_addr = vecs[v].sa; bus.char_addr = vecs[v].ca;
      bus.scr_addr  = vecs[v].ra; bus.obj_addr = vecs[v].oa;
      #1;
      chk($sformatf("v%0d_miss_ok", v), 32'(okv()), 32'd0);
      step();
      chk($sformatf("v%0d_req", v), 32'(bus.sdram_req), 32'd1);
      chk($sformatf("v%0d_addr", v), 32'(bus.sdram_addr), 32'(vecs[v].exp_addr));
      step();
      chk($sformatf("v%0d_req_hold", v), 32'(bus.sdram_req), 32'd1);
      ack_cycle();
      #1;
      chk($sformatf("v%0d_req_drop", v), 32'(bus.sdram_req), 32'd0);
      step();
      data_cycle(vecs[v].rd);
      chk($sformatf("v%0d_ok", v), 32'(okv()), 32'(vecs[v].exp_ok));
      chk($sformatf("v%0d_dout", v), 32'(dout(vecs[v].slot)), 32'(vecs[v].exp_dout));
      bus.main_cs = 0; bus.snd_cs = 0; bus.char_cs = 0; bus.scr_cs = 0; bus.obj_cs = 0;
      step();
    end

    // Main miss, then switch to the other byte of the cached word.
    clear_inputs();
    do_reset();
    bus.main_cs = 1; bus.main_addr = 17'h00123;
    expect_req("main", 22'h000091);
    ack_cycle();
    step();
    data_cycle(16'hABCD);
    chk("main_ok", 32'(bus.main_ok), 32'd1);
    chk("main_hi", 32'(bus.main_data), 32'hAB);
    bus.main_addr = 17'h00122;
    #1;
    chk("main_lo_ok", 32'(bus.main_ok), 32'd1);
    chk("main_lo", 32'(bus.main_data), 32'hCD);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin step(); reqs += 32'(bus.sdram_req); end
    chk("main_no_req", 32'(reqs), 32'd0);

    // Priority: main before obj; obj request two cycles after main fill.
    clear_inputs();
    do_reset();
    bus.main_cs = 1; bus.main_addr = 17'h00040; bus.obj_cs = 1; bus.obj_addr = 15'h0007;
    step();
    chk("prio_first", 32'(bus.sdram_addr), 32'h000020);
    ack_cycle();
    data_cycle(16'h0102);
    chk("prio_main_ok", 32'(bus.main_ok), 32'd1);
    chk("prio_gap", 32'(bus.sdram_req), 32'd0);
    step();
    chk("prio_obj_req", 32'(bus.sdram_req), 32'd1);
    chk("prio_obj_addr", 32'(bus.sdram_addr), 32'h022007);

    // Address change while the fill is outstanding.
    clear_inputs();
    do_reset();
    bus.char_cs = 1; bus.char_addr = 13'h0010;
    step();
    chk("chg_addr0", 32'(bus.sdram_addr), 32'h018010);
    ack_cycle();
    bus.char_addr = 13'h0011;
    data_cycle(16'h1111);
    chk("chg_stale_ok", 32'(bus.char_ok), 32'd0);
    step();
    chk("chg_req2", 32'(bus.sdram_req), 32'd1);
    chk("chg_addr2", 32'(bus.sdram_addr), 32'h018011);
    ack_cycle();
    data_cycle(16'h2222);
    chk("chg_ok", 32'(bus.char_ok), 32'd1);
    chk("chg_data", 32'(bus.char_data), 32'h2222);

    // Download during WAIT drops the fill and invalidates cached entries.
    clear_inputs();
    do_reset();
    bus.main_cs = 1; bus.main_addr = 17'h00123;
    expect_req("dl_main", 22'h000091);
    ack_cycle();
    data_cycle(16'hABCD);
    chk("dl_main_ok", 32'(bus.main_ok), 32'd1);
    bus.obj_cs = 1; bus.obj_addr = 15'h0003;
    expect_req("dl_obj", 22'h022003);
    ack_cycle();
    bus.downloading = 1;
    #1;
    chk("dl_main_drop", 32'(bus.main_ok), 32'd0);
    data_cycle(16'h7777);
    chk("dl_ok", 32'(okv()), 32'd0);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin step(); reqs += 32'(bus.sdram_req); end
    chk("dl_no_req", 32'(reqs), 32'd0);
    bus.downloading = 0;
    step();
    chk("dl_rereq", 32'(bus.sdram_req), 32'd1);
    chk("dl_rereq_addr", 32'(bus.sdram_addr), 32'h000091);

    // Asynchronous reset while a request is held.
    clear_inputs();
    do_reset();
    bus.main_cs = 1; bus.main_addr = 17'h00300;
    step();
    chk("ar_req_before", 32'(bus.sdram_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(bus.sdram_req), 32'd0);
    chk("ar_addr", 32'(bus.sdram_addr), 32'd0);
    chk("ar_ok", 32'(okv()), 32'd0);
    #1;
    rst = 1'b0;
    bus.main_cs = 0; bus.snd_cs = 1; bus.snd_addr = 15'h0004;
    expect_req("ar_snd", 22'h014002);

    // Offset overflow wraps.
    bus2.obj_cs = 1; bus2.obj_addr = 15'h0002;
    step();
    chk("wrap_req", 32'(bus2.sdram_req), 32'd1);
    chk("wrap_addr", 32'(bus2.sdram_addr), 32'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt1942_rom_arb.md
# jt1942_rom_arb

Single-port SDRAM read arbiter serving the game core's ROM request slots: main CPU, sound CPU, char, scroll and object. Each slot presents `*_cs`/`*_addr` and receives `*_data`/`*_ok`. The block keeps a one-word cache per slot and issues SDRAM reads on misses under fixed priority. It sits between the game top's ROM ports and the SDRAM controller read channel.

## Interface
Parameters
- `SND_OFFSET`, 22'h01_4000, word offset of sound ROM region
- `CHAR_OFFSET`, 22'h01_8000, word offset of char ROM region
- `SCR_OFFSET`, 22'h01_A000, word offset of scroll ROM region
- `OBJ_OFFSET`, 22'h02_2000, word offset of object ROM region (main offset fixed at 0)

Ports
- `clk`  in  1  system clock, 48 MHz
- `rst`  in  1  reset, asynchronous, active-high
- `downloading`  in  1  ROM download in progress
- `main_cs`  in  1  / `main_addr`  in  17  byte address / `main_data`  out  8 / `main_ok`  out  1
- `snd_cs`  in  1  / `snd_addr`  in  15  byte address / `snd_data`  out  8 / `snd_ok`  out  1
- `char_cs`  in  1  / `char_addr`  in  13  word address / `char_data`  out  16 / `char_ok`  out  1
- `scr_cs`  in  1  / `scr_addr`  in  15  word address / `scr_data`  out  16 / `scr_ok`  out  1
- `obj_cs`  in  1  / `obj_addr`  in  15  word address / `obj_data`  out  16 / `obj_ok`  out  1
- `sdram_req`  out  1  read request, held until acknowledged
- `sdram_addr`  out  22  16-bit word address
- `sdram_ack`  in  1  request accepted
- `data_rdy`  in  1  read data valid this cycle
- `data_read`  in  16  read data

## Operation
- Per slot cache: `cache_addr`, 16-bit `cache_data` and `valid`. All are cleared by reset.
- Word address per slot:
  - main uses `main_addr[16:1]`; snd uses `snd_addr[14:1]`.
  - Video slots use their address as given.
- Hit means `valid & (word address == cache_addr)`.
- Outputs are combinational from registered cache: `*_ok = *_cs & hit & ~downloading`.
- Byte slots output `cache_data[15:8]` when `addr[0]=1`, otherwise `cache_data[7:0]`. Video slots output `cache_data` directly.
- A slot is pending when `cs & ~hit & ~downloading`.
- FSM states:
  - IDLE: if any slot is pending, the highest-priority pending slot wins. Priority order is main > snd > char > scr > obj. The FSM latches the slot index and its word address, drives `sdram_addr = offset + word address`, sets `sdram_req`, and goes to REQ.
  - REQ: `sdram_req` stays high. When `sdram_ack=1` it clears `sdram_req` and goes to WAIT.
  - WAIT: on `data_rdy=1`, writes `data_read` and the latched address into the granted slot's cache, sets `valid` unless `downloading`, and goes to IDLE.
- If the slot address changes while its transaction is outstanding, the fill still completes with the latched address. The resulting mismatch raises a new request.
- `downloading` high clears every `valid` bit each cycle and blocks new grants. An outstanding REQ/WAIT transaction completes its handshake and its data is discarded.
- `cs` low never invalidates a cache entry.
- Address arithmetic is 22-bit modulo; offset overflow wraps silently.

## Timing
- Reset values: `sdram_req=0`, `sdram_addr=0`, FSM IDLE, all `*_ok=0`, all `*_data=0`.
- Miss to request: pending seen at edge N gives `sdram_req=1` with a stable `sdram_addr` from cycle N+1.
- `sdram_req` falls on the cycle after the `sdram_ack` edge. `data_rdy` is honoured only in WAIT.
- A `data_rdy` asserted in REQ, or in the same cycle as `sdram_ack`, is ignored. The controller contract forbids it.
- Fill to ok: `data_rdy` at edge K gives `*_ok=1` from cycle K+1, provided `cs` and the address are unchanged.
- On an address change, `ok` drops in the same cycle, combinationally, so stale data is never flagged valid.
- Back-to-back: IDLE is re-entered at K+1 and the next request is visible at K+2.
- Asynchronous `rst` mid-transaction aborts the FSM and clears caches immediately. The controller is re-synchronised by its own reset.

## Test plan
- Single main miss: `main_cs=1`, `main_addr=17'h00123`.
  - `sdram_addr=22'h000091` next cycle.
  - ack, then `data_rdy` with `data_read=16'hABCD`: `main_ok=1`, `main_data=8'hAB`.
  - Switching to `main_addr=17'h00122` keeps `main_ok=1` with `main_data=8'hCD`, and no new request is issued.
- Priority: `main_cs` and `obj_cs` miss in the same cycle.
  - The first request is `sdram_addr=22'h000000+main`.
  - The obj request (`OBJ_OFFSET+obj_addr`) is issued only after the main fill completes.
- Address change in flight: `char_addr` goes 13'h0010 → 13'h0011 during WAIT.
  - Fill for 0x0010 completes and `char_ok` stays 0.
  - A second request with `sdram_addr=CHAR_OFFSET+22'h11` follows, then `char_ok=1`.
- Download: `downloading=1` asserted during WAIT.
  - The handshake completes and all `*_ok=0`.
  - No `sdram_req` is issued while high.
  - After it drops, a previously cached address misses again.
- Reset mid-REQ: assert `rst` with `sdram_req=1`.
  - `sdram_req=0` and all `ok=0` immediately.
  - After release, a `snd_cs` miss on `snd_addr=15'h0004` requests `SND_OFFSET+22'h2`.
- Wrap: `OBJ_OFFSET=22'h3FFFFF`, `obj_addr=15'h0002` gives `sdram_addr=22'h000001`.
